// File: rtl/ccg_bist_ctrl.sv
// LFSR pattern generator and MISR response checker for a 25-in / 22-out benchmark netlist.
// Optional macro CCG_BIST_RESP_REG_EN registers dut_f before the MISR and adds a FLUSH state.
module ccg_bist_ctrl #(
  parameter logic [24:0] SEED     = 25'h0000001,
  parameter int unsigned PATTERNS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [21:0] golden_sig,
  output logic [24:0] dut_x,
  input  logic [21:0] dut_f,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [21:0] signature,
  output logic [15:0] pat_cnt
);

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_RUN  = 2'd1;
  localparam logic [1:0]  ST_DONE = 2'd3;
`ifdef CCG_BIST_RESP_REG_EN
  localparam logic [1:0]  ST_FLUSH = 2'd2;
`endif

  localparam logic [24:0] LP_SEED = (SEED == 25'd0) ? 25'h0000001 : SEED;
  localparam logic [15:0] LP_LAST = 16'(PATTERNS - 1);

  logic [1:0]  r_state;
  logic [24:0] r_x;
  logic [21:0] r_sig;
  logic [15:0] r_cnt;
  logic        r_pass;
  logic [24:0] w_lfsr_next;
  logic [21:0] w_misr_in;
  logic [21:0] w_sig_next;
  logic        w_last;

`ifdef CCG_BIST_RESP_REG_EN
  logic [21:0] r_resp;
  logic        r_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_resp <= '0;
    else        r_resp <= dut_f;
  end

  assign w_misr_in = r_resp;
`else
  assign w_misr_in = dut_f;
`endif

  assign w_lfsr_next = {r_x[23:0], r_x[24] ^ r_x[21]};
  assign w_sig_next  = {r_sig[20:0], r_sig[21] ^ r_sig[20]} ^ w_misr_in;
  assign w_last      = (r_cnt == LP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
`ifdef CCG_BIST_RESP_REG_EN
      r_cap   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_x     <= LP_SEED;
            r_sig   <= '0;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
`ifdef CCG_BIST_RESP_REG_EN
            r_cap   <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
`ifdef CCG_BIST_RESP_REG_EN
            // First RUN cycle has no registered response yet; FLUSH picks up the last one.
            r_cap <= 1'b1;
            if (r_cap) r_sig <= w_sig_next;
`else
            r_sig <= w_sig_next;
`endif
            if (w_last) begin
              r_x <= '0;
`ifdef CCG_BIST_RESP_REG_EN
              r_state <= ST_FLUSH;
`else
              r_state <= ST_DONE;
              r_pass  <= (w_sig_next == golden_sig);
`endif
            end else begin
              r_x <= w_lfsr_next;
            end
          end
        end
`ifdef CCG_BIST_RESP_REG_EN
        ST_FLUSH: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
          end else begin
            r_state <= ST_DONE;
            r_sig   <= w_sig_next;
            r_pass  <= (w_sig_next == golden_sig);
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dut_x     = r_x;
  assign signature = r_sig;
  assign pat_cnt   = r_cnt;
  assign pass      = r_pass;
  assign done      = (r_state == ST_DONE);
`ifdef CCG_BIST_RESP_REG_EN
  assign busy      = (r_state == ST_RUN) || (r_state == ST_FLUSH);
`else
  assign busy      = (r_state == ST_RUN);
`endif

endmodule

// File: tb/tb_ccg_bist_ctrl.sv
// Directed bench for ccg_bist_ctrl: pattern sequence, loopback signature, latency, abort, reset, ignored start.
module tb_ccg_bist_ctrl;

`ifdef CCG_BIST_RESP_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic [21:0] golden_sig = '0;

  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
  logic [24:0] x_a, x_b, x_c, x_d;
  logic [21:0] f_a;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic        done_a, done_b, done_c, done_d;
  logic        pass_a, pass_b, pass_c, pass_d;
  logic [21:0] sig_a, sig_b, sig_c, sig_d;
  logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;

  int n_total = 0;
  int n_bad   = 0;

  assign f_a = '0;

  always #5 clk = ~clk;

  ccg_bist_ctrl #(.SEED(25'h0000001), .PATTERNS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .golden_sig(golden_sig),
    .dut_x(x_a), .dut_f(f_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .pat_cnt(cnt_a));

  ccg_bist_ctrl #(.SEED(25'h0000001), .PATTERNS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .golden_sig(golden_sig),
    .dut_x(x_b), .dut_f(x_b[21:0]), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .pat_cnt(cnt_b));

  ccg_bist_ctrl #(.SEED(25'h0000001), .PATTERNS(1024)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort), .golden_sig(golden_sig),
    .dut_x(x_c), .dut_f(x_c[21:0]), .busy(busy_c), .done(done_c), .pass(pass_c),
    .signature(sig_c), .pat_cnt(cnt_c));

  ccg_bist_ctrl #(.SEED(25'h0000000), .PATTERNS(3)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .abort(abort), .golden_sig(golden_sig),
    .dut_x(x_d), .dut_f(x_d[21:0]), .busy(busy_d), .done(done_d), .pass(pass_d),
    .signature(sig_d), .pat_cnt(cnt_d));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int cyc;
    int busy_n;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_x",    32'(x_a), 32'h0);
    chk("rst_sig",  32'(sig_a), 32'h0);
    chk("rst_cnt",  32'(cnt_a), 32'h0);
    chk("rst_flags", {29'd0, busy_a, done_a, pass_a}, 32'h0);

    // Pattern sequence, dut_f tied low, golden 0
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("seq_busy", 32'(busy_a), 32'h1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("seq_x%0d", k), 32'(x_a), 32'h1 << k);
    end
    @(negedge clk);
    chk("seq_x_end", 32'(x_a), 32'h0);
    repeat (EXTRA) @(negedge clk);
    chk("seq_done", 32'(done_a), 32'h1);
    chk("seq_pass", 32'(pass_a), 32'h1);
    chk("seq_sig",  32'(sig_a), 32'h0);
    chk("seq_cnt",  32'(cnt_a), 32'h4);

    // Loopback, matching golden
    golden_sig = 22'h000004;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("lb_x0", 32'(x_b), 32'h1);
    cyc = 0;
    while (!done_b && cyc < 50) begin @(negedge clk); cyc++; end
    chk("lb_done", 32'(done_b), 32'h1);
    chk("lb_sig",  32'(sig_b), 32'h000004);
    chk("lb_pass", 32'(pass_b), 32'h1);

    // Loopback, mismatching golden; restart from DONE
    golden_sig = 22'h000005;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("lb2_done_clr", 32'(done_b), 32'h0);
    chk("lb2_cnt_clr",  32'(cnt_b), 32'h0);
    cyc = 0;
    while (!done_b && cyc < 50) begin @(negedge clk); cyc++; end
    chk("lb2_done", 32'(done_b), 32'h1);
    chk("lb2_sig",  32'(sig_b), 32'h000004);
    chk("lb2_pass", 32'(pass_b), 32'h0);

    // Latency and busy width
    start_c = 1'b1;
    cyc = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      start_c = 1'b0;
      cyc++;
      if (busy_c) busy_n++;
    end while (!done_c && cyc < 2000);
    chk("lat_done", 32'(cyc), 32'(1025 + EXTRA));
    chk("lat_busy", 32'(busy_n), 32'(1024 + EXTRA));
    chk("lat_cnt",  32'(cnt_c), 32'd1024);

    // Abort at pat_cnt=10
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    cyc = 0;
    while (cnt_c != 16'd10 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("ab_reach", 32'(cnt_c), 32'd10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_x",    32'(x_c), 32'h0);
    chk("ab_busy", 32'(busy_c), 32'h0);
    chk("ab_done", 32'(done_c), 32'h0);
    chk("ab_pass", 32'(pass_c), 32'h0);
    chk("ab_cnt",  32'(cnt_c), 32'd10);
    @(negedge clk);
    chk("ab_idle", 32'(busy_c), 32'h0);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    chk("ab_re_x",   32'(x_c), 32'h1);
    chk("ab_re_cnt", 32'(cnt_c), 32'h0);

    // Asynchronous reset mid-run at pat_cnt=500
    cyc = 0;
    while (cnt_c != 16'd500 && cyc < 600) begin @(negedge clk); cyc++; end
    chk("rs_reach", 32'(cnt_c), 32'd500);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_x",     32'(x_c), 32'h0);
    chk("rs_sig",   32'(sig_c), 32'h0);
    chk("rs_cnt",   32'(cnt_c), 32'h0);
    chk("rs_flags", {29'd0, busy_c, done_c, pass_c}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rs_idle_busy", 32'(busy_c), 32'h0);
    chk("rs_idle_x",    32'(x_c), 32'h0);

    // Start ignored in RUN, SEED=0 substituted by 1
    golden_sig = 22'h000004;
    start_d = 1'b1;
    @(negedge clk);
    chk("s0_x0", 32'(x_d), 32'h1);
    @(negedge clk);
    start_d = 1'b0;
    chk("s0_x1", 32'(x_d), 32'h2);
    @(negedge clk);
    chk("s0_x2", 32'(x_d), 32'h4);
    cyc = 0;
    while (!done_d && cyc < 50) begin @(negedge clk); cyc++; end
    chk("s0_done", 32'(done_d), 32'h1);
    chk("s0_sig",  32'(sig_d), 32'h000004);
    chk("s0_pass", 32'(pass_d), 32'h1);
    chk("s0_cnt",  32'(cnt_d), 32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
